// File: rtl/phys_reg_read_pkg.sv
// Shared constants, FSM state type and writeback-match helper for the
// physical-register operand-read stage.
package phys_reg_read_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_PREGS  = 64;
  localparam int PREG_TAG_W = $clog2(NUM_PREGS);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] value;
  } wb_pick_t;

  // Port 2 is checked first so it wins when both ports carry the same tag.
  function automatic wb_pick_t wb_pick(
    input logic [PREG_TAG_W-1:0] tag,
    input logic                  en1,
    input logic [PREG_TAG_W-1:0] tag1,
    input logic [DATA_W-1:0]     val1,
    input logic                  en2,
    input logic [PREG_TAG_W-1:0] tag2,
    input logic [DATA_W-1:0]     val2
  );
    wb_pick_t r;
    r.hit   = 1'b0;
    r.value = '0;
    if (en2 && tag2 == tag) begin
      r.hit   = 1'b1;
      r.value = val2;
    end else if (en1 && tag1 == tag) begin
      r.hit   = 1'b1;
      r.value = val1;
    end
    return r;
  endfunction

endpackage

// File: rtl/phys_reg_read_if.sv
// Issue-side and execute-side valid/ready channels of the operand-read stage.
interface phys_reg_read_if #(
  parameter int PAYLOAD_W = 32
);
  import phys_reg_read_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [PREG_TAG_W-1:0] in_src1;
  logic [PREG_TAG_W-1:0] in_src2;
  logic                  in_use1;
  logic                  in_use2;
  logic [PAYLOAD_W-1:0]  in_payload;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_op1;
  logic [DATA_W-1:0]     out_op2;
  logic [PAYLOAD_W-1:0]  out_payload;

  modport master (
    output in_valid, in_src1, in_src2, in_use1, in_use2, in_payload, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_payload
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_use1, in_use2, in_payload, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_payload
  );

endinterface

// File: rtl/phys_reg_scoreboard.sv
// 64-entry ready table: writebacks set, allocation clears (clear wins),
// with combinational lookup on two read tags.
module phys_reg_scoreboard
  import phys_reg_read_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set1_en,
  input  logic [PREG_TAG_W-1:0] set1_tag,
  input  logic                  set2_en,
  input  logic [PREG_TAG_W-1:0] set2_tag,
  input  logic                  clr_en,
  input  logic [PREG_TAG_W-1:0] clr_tag,
  input  logic [PREG_TAG_W-1:0] rd1_tag,
  input  logic [PREG_TAG_W-1:0] rd2_tag,
  output logic                  rd1_ready,
  output logic                  rd2_ready
);

  logic [NUM_PREGS-1:0] ready_reg;
  logic [NUM_PREGS-1:0] ready_next;

  for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_bit
    logic set_hit;
    logic clr_hit;
    assign set_hit = (set1_en && set1_tag == PREG_TAG_W'(gi)) ||
                     (set2_en && set2_tag == PREG_TAG_W'(gi));
    assign clr_hit = clr_en && clr_tag == PREG_TAG_W'(gi);
    assign ready_next[gi] = !clr_hit && (set_hit || ready_reg[gi]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_reg <= '1;
    else        ready_reg <= ready_next;
  end

  assign rd1_ready = ready_reg[rd1_tag];
  assign rd2_ready = ready_reg[rd2_tag];

endmodule

// File: rtl/phys_reg_read.sv
// Operand-read stage: resolves two source operands from bypass, register file
// or later writebacks, then holds them for the execute stage.
module phys_reg_read
  import phys_reg_read_pkg::*;
#(
  parameter int PAYLOAD_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  phys_reg_read_if.slave                   bus,
  input  logic [NUM_PREGS-1:0][DATA_W-1:0] regs,
  input  logic [PREG_TAG_W-1:0]            wb1_reg,
  input  logic [PREG_TAG_W-1:0]            wb2_reg,
  input  logic [DATA_W-1:0]                wb1_value,
  input  logic [DATA_W-1:0]                wb2_value,
  input  logic                             wb1_en,
  input  logic                             wb2_en,
  input  logic                             wb_stall,
  input  logic                             alloc_en,
  input  logic [PREG_TAG_W-1:0]            alloc_reg
);

  state_t                state_reg;
  logic [DATA_W-1:0]     op1_reg, op2_reg;
  logic [PAYLOAD_W-1:0]  payload_reg;
  logic                  pend1_reg, pend2_reg;
  logic [PREG_TAG_W-1:0] tag1_reg, tag2_reg;

  logic                  wb1_eff, wb2_eff, rdy1, rdy2, accept;
  wb_pick_t              byp1, byp2, cap1, cap2;
  logic [DATA_W-1:0]     acc_op1, acc_op2;
  logic                  acc_pend1, acc_pend2;

  assign wb1_eff = wb1_en && !wb_stall;
  assign wb2_eff = wb2_en && !wb_stall;

  phys_reg_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set1_en   (wb1_eff),
    .set1_tag  (wb1_reg),
    .set2_en   (wb2_eff),
    .set2_tag  (wb2_reg),
    .clr_en    (alloc_en),
    .clr_tag   (alloc_reg),
    .rd1_tag   (bus.in_src1),
    .rd2_tag   (bus.in_src2),
    .rd1_ready (rdy1),
    .rd2_ready (rdy2)
  );

  // Bypass at accept uses the incoming tags; capture while waiting uses the latched ones.
  assign byp1 = wb_pick(bus.in_src1, wb1_eff, wb1_reg, wb1_value, wb2_eff, wb2_reg, wb2_value);
  assign byp2 = wb_pick(bus.in_src2, wb1_eff, wb1_reg, wb1_value, wb2_eff, wb2_reg, wb2_value);
  assign cap1 = wb_pick(tag1_reg, wb1_eff, wb1_reg, wb1_value, wb2_eff, wb2_reg, wb2_value);
  assign cap2 = wb_pick(tag2_reg, wb1_eff, wb1_reg, wb1_value, wb2_eff, wb2_reg, wb2_value);

  always_comb begin
    acc_op1   = '0;
    acc_pend1 = 1'b0;
    acc_op2   = '0;
    acc_pend2 = 1'b0;
    if (bus.in_use1) begin
      if (byp1.hit)  acc_op1 = byp1.value;
      else if (rdy1) acc_op1 = regs[bus.in_src1];
      else           acc_pend1 = 1'b1;
    end
    if (bus.in_use2) begin
      if (byp2.hit)  acc_op2 = byp2.value;
      else if (rdy2) acc_op2 = regs[bus.in_src2];
      else           acc_pend2 = 1'b1;
    end
  end

  assign bus.in_ready    = !flush && (state_reg == IDLE || (state_reg == FULL && bus.out_ready));
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = (state_reg == FULL);
  assign bus.out_op1     = op1_reg;
  assign bus.out_op2     = op2_reg;
  assign bus.out_payload = payload_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      op1_reg     <= '0;
      op2_reg     <= '0;
      payload_reg <= '0;
      pend1_reg   <= 1'b0;
      pend2_reg   <= 1'b0;
      tag1_reg    <= '0;
      tag2_reg    <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      pend1_reg <= 1'b0;
      pend2_reg <= 1'b0;
    end else begin
      case (state_reg)
        WAIT: begin
          if (pend1_reg && cap1.hit) begin
            op1_reg   <= cap1.value;
            pend1_reg <= 1'b0;
          end
          if (pend2_reg && cap2.hit) begin
            op2_reg   <= cap2.value;
            pend2_reg <= 1'b0;
          end
          if (!(pend1_reg && !cap1.hit) && !(pend2_reg && !cap2.hit))
            state_reg <= FULL;
        end
        IDLE, FULL: begin
          if (accept) begin
            op1_reg     <= acc_op1;
            op2_reg     <= acc_op2;
            payload_reg <= bus.in_payload;
            pend1_reg   <= acc_pend1;
            pend2_reg   <= acc_pend2;
            tag1_reg    <= bus.in_src1;
            tag2_reg    <= bus.in_src2;
            state_reg   <= (acc_pend1 || acc_pend2) ? WAIT : FULL;
          end else if (state_reg == FULL && bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phys_reg_read.sv
// Directed and randomized bench for phys_reg_read against a transaction-level
// model of scoreboard, register file and held instruction.
module tb_phys_reg_read;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [63:0][31:0] regs;
  logic [5:0]        wb1_reg, wb2_reg, alloc_reg;
  logic [31:0]       wb1_value, wb2_value;
  logic              wb1_en, wb2_en, wb_stall, alloc_en;

  phys_reg_read_if #(.PAYLOAD_W(32)) bus ();

  phys_reg_read #(.PAYLOAD_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .regs      (regs),
    .wb1_reg   (wb1_reg),
    .wb2_reg   (wb2_reg),
    .wb1_value (wb1_value),
    .wb2_value (wb2_value),
    .wb1_en    (wb1_en),
    .wb2_en    (wb2_en),
    .wb_stall  (wb_stall),
    .alloc_en  (alloc_en),
    .alloc_reg (alloc_reg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model: 0 = nothing held, 1 = waiting on writebacks, 2 = presenting operands.
  int          m_state;
  logic [31:0] m_op1, m_op2, m_pay;
  bit          m_p1, m_p2;
  logic [5:0]  m_t1, m_t2;
  bit          sb[64];
  logic [31:0] rf[64];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !flush && (m_state == 0 || (m_state == 2 && bus.out_ready));
  endfunction

  function automatic bit wb_hit(input logic [5:0] tag, input bit e1, input bit e2,
                                output logic [31:0] v);
    v = 32'h0;
    if (e2 && wb2_reg == tag) begin v = wb2_value; return 1'b1; end
    if (e1 && wb1_reg == tag) begin v = wb1_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic void resolve(input bit used, input logic [5:0] tag, input bit e1,
                                  input bit e2, output logic [31:0] val, output bit pend);
    logic [31:0] v;
    val  = 32'h0;
    pend = 1'b0;
    if (!used) return;
    if (wb_hit(tag, e1, e2, v)) val = v;
    else if (sb[tag])           val = rf[tag];
    else                        pend = 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_op1 = 32'h0; m_op2 = 32'h0; m_pay = 32'h0;
    m_p1 = 1'b0; m_p2 = 1'b0;
    for (int i = 0; i < 64; i++) sb[i] = 1'b1;
  endtask

  task automatic model_step();
    bit e1, e2, acc;
    logic [31:0] v;
    if (!reset) return;
    e1  = wb1_en && !wb_stall;
    e2  = wb2_en && !wb_stall;
    acc = bus.in_valid && exp_ready();
    if (flush) begin
      m_state = 0; m_p1 = 1'b0; m_p2 = 1'b0;
    end else if (m_state == 1) begin
      if (m_p1 && wb_hit(m_t1, e1, e2, v)) begin m_op1 = v; m_p1 = 1'b0; end
      if (m_p2 && wb_hit(m_t2, e1, e2, v)) begin m_op2 = v; m_p2 = 1'b0; end
      if (!m_p1 && !m_p2) m_state = 2;
    end else if (acc) begin
      if (m_state == 2)
        $display("xfer op1=%h op2=%h pay=%h (back-to-back)", m_op1, m_op2, m_pay);
      resolve(bus.in_use1, bus.in_src1, e1, e2, m_op1, m_p1);
      resolve(bus.in_use2, bus.in_src2, e1, e2, m_op2, m_p2);
      m_t1 = bus.in_src1; m_t2 = bus.in_src2; m_pay = bus.in_payload;
      m_state = (m_p1 || m_p2) ? 1 : 2;
    end else if (m_state == 2 && bus.out_ready) begin
      $display("xfer op1=%h op2=%h pay=%h", m_op1, m_op2, m_pay);
      m_state = 0;
    end
    if (e1) begin sb[wb1_reg] = 1'b1; rf[wb1_reg] = wb1_value; end
    if (e2) begin sb[wb2_reg] = 1'b1; rf[wb2_reg] = wb2_value; end
    if (alloc_en) sb[alloc_reg] = 1'b0;
  endtask

  // Inputs and the register-file vector change only 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 64; i++) regs[i] = rf[i];
  endtask

  task automatic clear_inputs();
    flush = 1'b0; bus.in_valid = 1'b0; bus.in_use1 = 1'b0; bus.in_use2 = 1'b0;
    bus.in_src1 = 6'd0; bus.in_src2 = 6'd0; bus.in_payload = 32'h0; bus.out_ready = 1'b0;
    wb1_en = 1'b0; wb2_en = 1'b0; wb_stall = 1'b0; alloc_en = 1'b0;
    wb1_reg = 6'd0; wb2_reg = 6'd0; alloc_reg = 6'd0; wb1_value = 32'h0; wb2_value = 32'h0;
  endtask

  task automatic issue(input logic [5:0] s1, input bit u1, input logic [5:0] s2,
                       input bit u2, input logic [31:0] pay);
    bus.in_valid = 1'b1; bus.in_src1 = s1; bus.in_use1 = u1;
    bus.in_src2 = s2; bus.in_use2 = u2; bus.in_payload = pay;
  endtask

  function automatic logic [5:0] rtag();
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("out_valid", 32'(bus.out_valid), 32'(m_state == 2));
      cmp("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
      if (m_state == 2) begin
        cmp("out_op1", bus.out_op1, m_op1);
        cmp("out_op2", bus.out_op2, m_op2);
        cmp("out_payload", bus.out_payload, m_pay);
      end
    end
  end

  initial begin
    clear_inputs();
    for (int i = 0; i < 64; i++) rf[i] = $urandom;
    rf[5] = 32'h11;
    rf[9] = 32'h22;
    for (int i = 0; i < 64; i++) regs[i] = rf[i];
    model_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #20 reset = 1'b1;
    chk_on = 1'b1;
    cmp("rst_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst_ready", 32'(bus.in_ready), 32'd1);
    cmp("rst_op1", bus.out_op1, 32'h0);
    cmp("rst_payload", bus.out_payload, 32'h0);

    // Both operands ready at accept.
    issue(6'd5, 1, 6'd9, 1, 32'hCAFE); tick(); clear_inputs();
    cmp("t1_valid", 32'(bus.out_valid), 32'd1);
    cmp("t1_op1", bus.out_op1, 32'h11);
    cmp("t1_op2", bus.out_op2, 32'h22);
    bus.out_ready = 1'b1; tick(); clear_inputs();
    cmp("t1_drain", 32'(bus.out_valid), 32'd0);

    // Allocated tag waits for a later writeback.
    alloc_en = 1'b1; alloc_reg = 6'd7; tick(); clear_inputs();
    issue(6'd7, 1, 6'd0, 0, 32'h1); tick(); clear_inputs();
    cmp("t2_wait", 32'(bus.out_valid), 32'd0);
    tick();
    wb1_en = 1'b1; wb1_reg = 6'd7; wb1_value = 32'hABCD; tick(); clear_inputs();
    cmp("t2_valid", 32'(bus.out_valid), 32'd1);
    cmp("t2_op1", bus.out_op1, 32'hABCD);
    cmp("t2_op2", bus.out_op2, 32'h0);
    bus.out_ready = 1'b1; tick(); clear_inputs();
    cmp("t2_idle", 32'(bus.out_valid), 32'd0);

    // Dual writeback to the same tag: port 2 wins; alloc beats a same-cycle wb.
    issue(6'd3, 1, 6'd0, 0, 32'h2);
    wb1_en = 1'b1; wb1_reg = 6'd3; wb1_value = 32'h1;
    wb2_en = 1'b1; wb2_reg = 6'd3; wb2_value = 32'h2;
    tick(); clear_inputs();
    cmp("t3_op1", bus.out_op1, 32'h2);
    bus.out_ready = 1'b1; tick(); clear_inputs();
    alloc_en = 1'b1; alloc_reg = 6'd3; wb1_en = 1'b1; wb1_reg = 6'd3; wb1_value = 32'h9;
    tick(); clear_inputs();
    issue(6'd3, 1, 6'd0, 0, 32'h3); tick(); clear_inputs();
    cmp("t3_wait", 32'(bus.out_valid), 32'd0);
    wb2_en = 1'b1; wb2_reg = 6'd3; wb2_value = 32'h33; tick(); clear_inputs();
    cmp("t3_op1b", bus.out_op1, 32'h33);
    bus.out_ready = 1'b1; tick(); clear_inputs();

    // Hold under backpressure, then back-to-back accept.
    issue(6'd5, 1, 6'd9, 1, 32'h44); tick(); clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick(); clear_inputs();
      cmp("t4_hold_op1", bus.out_op1, 32'h11);
      cmp("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1; issue(6'd9, 1, 6'd5, 1, 32'h55); tick(); clear_inputs();
    cmp("t4_b2b_valid", 32'(bus.out_valid), 32'd1);
    cmp("t4_b2b_op1", bus.out_op1, 32'h22);
    cmp("t4_b2b_op2", bus.out_op2, 32'h11);
    cmp("t4_b2b_pay", bus.out_payload, 32'h55);
    bus.out_ready = 1'b1; tick(); clear_inputs();

    // Stalled writeback is ignored.
    alloc_en = 1'b1; alloc_reg = 6'd12; tick(); clear_inputs();
    issue(6'd12, 1, 6'd0, 0, 32'h6); tick(); clear_inputs();
    wb_stall = 1'b1; wb1_en = 1'b1; wb1_reg = 6'd12; wb1_value = 32'h55; tick(); clear_inputs();
    cmp("t5_stall", 32'(bus.out_valid), 32'd0);
    wb1_en = 1'b1; wb1_reg = 6'd12; wb1_value = 32'h66; tick(); clear_inputs();
    cmp("t5_valid", 32'(bus.out_valid), 32'd1);
    cmp("t5_op1", bus.out_op1, 32'h66);
    bus.out_ready = 1'b1; tick(); clear_inputs();

    // Flush in WAIT and FULL; scoreboard survives flush.
    alloc_en = 1'b1; alloc_reg = 6'd20; tick(); clear_inputs();
    issue(6'd20, 1, 6'd0, 0, 32'h7); tick(); clear_inputs();
    flush = 1'b1; tick(); clear_inputs();
    cmp("t6_flush_wait", 32'(bus.out_valid), 32'd0);
    issue(6'd20, 1, 6'd0, 0, 32'h8); tick(); clear_inputs();
    cmp("t6_sb_kept", 32'(bus.out_valid), 32'd0);
    flush = 1'b1; tick(); clear_inputs();
    issue(6'd5, 1, 6'd9, 1, 32'h9); tick(); clear_inputs();
    flush = 1'b1; issue(6'd9, 1, 6'd9, 1, 32'hA);
    cmp("t6_flush_ready", 32'(bus.in_ready), 32'd0);
    tick(); clear_inputs();
    cmp("t6_flush_full", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while waiting.
    alloc_en = 1'b1; alloc_reg = 6'd21; tick(); clear_inputs();
    issue(6'd21, 1, 6'd0, 0, 32'hB); tick(); clear_inputs();
    cmp("t7_wait", 32'(bus.out_valid), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    #1;
    cmp("t7_rst_valid", 32'(bus.out_valid), 32'd0);
    cmp("t7_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #3 reset = 1'b1;
    issue(6'd21, 1, 6'd0, 0, 32'hC); tick(); clear_inputs();
    cmp("t7_valid", 32'(bus.out_valid), 32'd1);
    cmp("t7_op1", bus.out_op1, rf[21]);
    bus.out_ready = 1'b1; tick(); clear_inputs();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 6);
      bus.in_src1    = rtag();
      bus.in_src2    = rtag();
      bus.in_use1    = ($urandom_range(0, 9) < 8);
      bus.in_use2    = ($urandom_range(0, 9) < 7);
      bus.in_payload = $urandom;
      bus.out_ready  = ($urandom_range(0, 9) < 7);
      wb1_en    = ($urandom_range(0, 9) < 4);
      wb1_reg   = rtag();
      wb1_value = $urandom;
      wb2_en    = ($urandom_range(0, 9) < 4);
      wb2_reg   = rtag();
      wb2_value = $urandom;
      wb_stall  = ($urandom_range(0, 9) == 0);
      alloc_en  = ($urandom_range(0, 9) < 2);
      alloc_reg = rtag();
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
